// File: rtl/mem_wait_responder.sv
// Single-port RAM slave for a valid/ready core bus that inserts bounded wait states.
// Each transaction runs IDLE -> WAIT -> RESP -> DRAIN; a mid-transaction request change sets a sticky flag.
module mem_wait_responder #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        wait_req,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        proto_err,
  output logic [2:0]  last_wait
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [31:0]          r_mem [0:DEPTH-1];

  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_stall;
  logic                 w_enter_resp;
  logic                 w_viol;
  logic                 w_unused;

  // The fetch/data distinction carries no meaning for this slave.
  assign w_unused = &{1'b0, mem_instr};

  assign w_in_range   = (r_addr >> (ADDR_BITS + 2)) == 32'd0;
  assign w_idx        = r_addr[ADDR_BITS+1:2];
  assign w_stall      = wait_req && (r_cnt < CW'(MAX_WAIT));
  assign w_enter_resp = (r_state == S_WAIT) && !w_stall;
  assign w_viol       = (r_state == S_WAIT) &&
                        (!mem_valid || (mem_addr != r_addr) ||
                         (mem_wdata != r_wdata) || (mem_wstrb != r_wstrb));

  // Next-state and wait counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (w_stall) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request snapshot taken on acceptance; the transaction completes from it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if ((r_state == S_IDLE) && mem_valid) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
    end
  end

  // Response outputs are loaded on the WAIT->RESP edge and live for the RESP cycle only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      proto_err <= 1'b0;
      last_wait <= '0;
    end else begin
      mem_ready <= w_enter_resp;
      bus_err   <= w_enter_resp && !w_in_range;
      mem_rdata <= (w_enter_resp && w_in_range && (r_wstrb == 4'd0)) ? r_mem[w_idx] : 32'd0;
      proto_err <= proto_err || w_viol;
      if (w_enter_resp) begin
        last_wait <= r_cnt;
      end
    end
  end

  // RAM is never reset; reset forces IDLE asynchronously so no write can commit afterwards.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
